// File: rtl/axi_ahb_pkg.sv
// Shared types and helpers for the AXI-to-AHB bridge arbitration logic.
//
// Contents:
//   htrans_t      - AHB HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   dir_t         - transfer direction (DIR_R, DIR_W)
//   HTRANS_*      - HTRANS encodings as plain 2-bit constants
//   rr_pick()     - round-robin pick between the write and read candidates
//
// Optional feature macro used by ahb_rw_arbiter: AXI_AHB_ARB_BURST_LOCK_EN
package axi_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_W = 1'b1
    } dir_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Returns {pick_w, pick_r}. On contention the direction that was not
    // granted last wins; at most one bit is ever set.
    function automatic logic [1:0] rr_pick(input logic w_cand,
                                           input logic r_cand,
                                           input dir_t last_dir);
        logic [1:0] pick;
        pick = 2'b00;
        case ({w_cand, r_cand})
            2'b10:   pick = 2'b10;
            2'b01:   pick = 2'b01;
            2'b11:   pick = (last_dir == DIR_R) ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/ahb_rw_arbiter_if.sv
// Bundle of request, grant and AHB address-phase signals between the
// bridge request logic and ahb_rw_arbiter.
//
// Signals:
//   w_req/w_last, r_req/r_last  beat requests and end-of-burst flags
//   hready                      AHB pipeline-advance
//   grant_w/grant_r             pop strobes back to the request FIFOs
//   htrans/hwrite               AHB address-phase controls
//   w_phase1/r_phase1           direction occupying the address phase
//   w_phase2/r_phase2           direction occupying the data phase
//
// Modports: slave = the arbiter, master = the logic driving it.
interface ahb_rw_arbiter_if;

    logic       w_req;
    logic       w_last;
    logic       r_req;
    logic       r_last;
    logic       hready;
    logic       grant_w;
    logic       grant_r;
    logic [1:0] htrans;
    logic       hwrite;
    logic       w_phase1;
    logic       r_phase1;
    logic       w_phase2;
    logic       r_phase2;

    modport slave (
        input  w_req, w_last, r_req, r_last, hready,
        output grant_w, grant_r, htrans, hwrite,
               w_phase1, r_phase1, w_phase2, r_phase2
    );

    modport master (
        output w_req, w_last, r_req, r_last, hready,
        input  grant_w, grant_r, htrans, hwrite,
               w_phase1, r_phase1, w_phase2, r_phase2
    );

endinterface

// File: rtl/ahb_rw_arbiter.sv
// Shares the single AHB master port between the bridge write and read paths.
// Each hready=1 cycle at most one beat is granted; the AHB address-phase
// controls and the address/data phase ownership flags are registered.
//
// Ports:
//   clk    bridge clock
//   rst_n  asynchronous active-low reset
//   bus    ahb_rw_arbiter_if.slave (requests in; grants, htrans, hwrite,
//          phase flags out)
// Parameter:
//   MAX_HOLD  consecutive beats one direction may take while the other
//             direction waits (1..255)
//
// Optional feature: define AXI_AHB_ARB_BURST_LOCK_EN to keep an AXI burst on
// the bus as one SEQ-linked AHB burst (still broken by MAX_HOLD).
module ahb_rw_arbiter
    import axi_ahb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ahb_rw_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    dir_t       last_dir_r;
    logic [7:0] hold_cnt_r;
    logic [1:0] htrans_r;
    logic       hwrite_r;
    logic       w_phase1_r;
    logic       r_phase1_r;
    logic       w_phase2_r;
    logic       r_phase2_r;

    logic       hold_full_s;
    logic       w_block_s;
    logic       r_block_s;
    logic       w_cand_s;
    logic       r_cand_s;
    logic       seq_s;
    logic [1:0] pick_s;
    logic       grant_w_s;
    logic       grant_r_s;
    dir_t       grant_dir_s;
    logic [1:0] htrans_next_s;
    logic [7:0] hold_next_s;

`ifdef AXI_AHB_ARB_BURST_LOCK_EN
    logic       lock_on_r;
    dir_t       lock_dir_r;
    logic       lock_gap_r;
    logic       locked_s;
`else
    logic       unused_last_s;
    assign unused_last_s = bus.w_last ^ bus.r_last;
`endif

    // Starvation guard: the direction that used up its hold budget yields
    // as soon as the other direction is waiting.
    always_comb begin
        hold_full_s = (hold_cnt_r >= HOLD_LIMIT);
        w_block_s   = hold_full_s && (last_dir_r == DIR_W) && bus.r_req;
        r_block_s   = hold_full_s && (last_dir_r == DIR_R) && bus.w_req;
    end

    // Candidate selection; an active lock narrows the field to the locked
    // direction unless the hold budget forces a break.
    always_comb begin
        w_cand_s = bus.w_req && !w_block_s;
        r_cand_s = bus.r_req && !r_block_s;
        seq_s    = 1'b0;
`ifdef AXI_AHB_ARB_BURST_LOCK_EN
        locked_s = lock_on_r && !(w_block_s || r_block_s);
        if (locked_s) begin
            w_cand_s = bus.w_req && (lock_dir_r == DIR_W);
            r_cand_s = bus.r_req && (lock_dir_r == DIR_R);
            // After an IDLE inside the burst the AHB burst must restart.
            seq_s    = !lock_gap_r;
        end else begin
            seq_s    = 1'b0;
        end
`endif
    end

    // Grant decode plus next htrans and hold-counter values.
    always_comb begin
        pick_s        = rr_pick(w_cand_s, r_cand_s, last_dir_r);
        // Gated by rst_n so no pop strobe escapes while in reset.
        grant_w_s     = rst_n && bus.hready && pick_s[1];
        grant_r_s     = rst_n && bus.hready && pick_s[0];
        grant_dir_s   = grant_w_s ? DIR_W : DIR_R;
        htrans_next_s = HTRANS_IDLE;
        hold_next_s   = hold_cnt_r;
        if (grant_w_s || grant_r_s) begin
            htrans_next_s = seq_s ? HTRANS_SEQ : HTRANS_NONSEQ;
            if (grant_dir_s == last_dir_r) begin
                hold_next_s = hold_full_s ? hold_cnt_r : (hold_cnt_r + 8'd1);
            end else begin
                hold_next_s = 8'd1;
            end
        end else begin
            htrans_next_s = HTRANS_IDLE;
            hold_next_s   = hold_cnt_r;
        end
    end

    // AHB address/data phase pipeline; frozen while hready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            htrans_r   <= HTRANS_IDLE;
            hwrite_r   <= 1'b0;
            w_phase1_r <= 1'b0;
            r_phase1_r <= 1'b0;
            w_phase2_r <= 1'b0;
            r_phase2_r <= 1'b0;
        end else if (bus.hready) begin
            htrans_r   <= htrans_next_s;
            hwrite_r   <= grant_w_s;
            w_phase1_r <= grant_w_s;
            r_phase1_r <= grant_r_s;
            w_phase2_r <= w_phase1_r;
            r_phase2_r <= r_phase1_r;
        end
    end

    // Round-robin history and hold counter, updated only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir_r <= DIR_R;
            hold_cnt_r <= 8'd0;
        end else if (grant_w_s || grant_r_s) begin
            last_dir_r <= grant_dir_s;
            hold_cnt_r <= hold_next_s;
        end
    end

`ifdef AXI_AHB_ARB_BURST_LOCK_EN
    // Burst lock: set by a non-last beat, cleared by a last beat; an idle
    // arbitration point keeps the lock but marks the AHB burst as broken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_on_r  <= 1'b0;
            lock_dir_r <= DIR_R;
            lock_gap_r <= 1'b0;
        end else if (grant_w_s) begin
            lock_on_r  <= !bus.w_last;
            lock_dir_r <= DIR_W;
            lock_gap_r <= 1'b0;
        end else if (grant_r_s) begin
            lock_on_r  <= !bus.r_last;
            lock_dir_r <= DIR_R;
            lock_gap_r <= 1'b0;
        end else if (bus.hready) begin
            lock_gap_r <= 1'b1;
        end
    end
`endif

    assign bus.grant_w  = grant_w_s;
    assign bus.grant_r  = grant_r_s;
    assign bus.htrans   = htrans_r;
    assign bus.hwrite   = hwrite_r;
    assign bus.w_phase1 = w_phase1_r;
    assign bus.r_phase1 = r_phase1_r;
    assign bus.w_phase2 = w_phase2_r;
    assign bus.r_phase2 = r_phase2_r;

endmodule

// File: tb/tb_ahb_rw_arbiter.sv
// Directed self-checking bench for ahb_rw_arbiter. Grants are checked in the
// cycle they are requested; the expected registered outputs are queued when
// a step is driven and compared one cycle later. Expectations adapt to
// whether AXI_AHB_ARB_BURST_LOCK_EN is defined.
module tb_ahb_rw_arbiter;
    import axi_ahb_pkg::*;

    localparam int unsigned HOLD = 4;
`ifdef AXI_AHB_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] S = HTRANS_SEQ;
    localparam logic [1:0] I = HTRANS_IDLE;

    typedef struct packed {
        logic [1:0] ht;
        logic       hw;
        logic       wp1;
        logic       rp1;
        logic       wp2;
        logic       rp2;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e = '0;

    always #5 clk = ~clk;

    ahb_rw_arbiter_if bus();

    ahb_rw_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return 16'({bus.htrans, bus.hwrite, bus.w_phase1, bus.r_phase1,
                    bus.w_phase2, bus.r_phase2});
    endfunction

    // One cycle: drive, check grants, check last cycle's registered outputs,
    // queue this cycle's expected registered outputs.
    task automatic step(input string tag, input logic wr, input logic wl,
                        input logic rr, input logic rl, input logic hr,
                        input logic egw, input logic egr, input logic [1:0] eht);
        exp_t p;
        bus.w_req  = wr;
        bus.w_last = wl;
        bus.r_req  = rr;
        bus.r_last = rl;
        bus.hready = hr;
        #3;
        chk({tag, " grant"}, 16'({bus.grant_w, bus.grant_r}), 16'({egw, egr}));
        if (q.size() > 0) begin
            p = q.pop_front();
            chk({tag, " outs"}, outs(), 16'(p));
        end
        if (hr) begin
            e.wp2 = e.wp1;
            e.rp2 = e.rp1;
            e.wp1 = egw;
            e.rp1 = egr;
            e.hw  = egw;
            e.ht  = eht;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " grants"}, 16'({bus.grant_w, bus.grant_r}), 16'd0);
        chk({tag, " outs"}, outs(), 16'd0);
    endtask

    initial begin
        bus.w_req  = 1'b0;
        bus.w_last = 1'b0;
        bus.r_req  = 1'b0;
        bus.r_last = 1'b0;
        bus.hready = 1'b0;
        #2;
        bus.w_req  = 1'b1;
        bus.r_req  = 1'b1;
        bus.hready = 1'b1;
        #1;
        reset_check("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention without lock: strict alternation starting with write.
        for (int i = 0; i < 6; i++) begin
            step("cont", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'((i % 2) == 0), 1'((i % 2) == 1), N);
        end

        // Wait states freeze everything registered and suppress grants.
        step("ws_g", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, N);
        for (int i = 0; i < 3; i++) begin
            step("ws", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, I);
        end
        step("ws_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, I);
        step("r1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);

        // Four-beat write burst against a waiting read.
        step("lb1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        step("lb2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, LOCK, !LOCK, LOCK ? S : N);
        step("lb3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, LOCK ? S : N);
        step("lb4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, LOCK, !LOCK, LOCK ? S : N);
        step("lb5", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);

        // Write request gap inside a locked burst.
        step("ig1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        step("ig2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, !LOCK, LOCK ? I : N);
        step("ig3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        step("ig4", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);

        // Five-beat write burst broken by the hold limit.
        step("sb1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        step("sb2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, LOCK, !LOCK, LOCK ? S : N);
        step("sb3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, LOCK ? S : N);
        step("sb4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, LOCK, !LOCK, LOCK ? S : N);
        step("sb5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, !LOCK, LOCK, N);
        step("sb6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, LOCK, !LOCK, N);
        step("sb7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);

        // Write-only stream fills the hold budget, then read gets in.
        for (int i = 0; i < 5; i++) begin
            step("hold_w", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, N);
        end
        step("hold_r", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);

        // Reset in the middle of a burst clears everything at once.
        step("mb1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        rst_n = 1'b0;
        #1;
        reset_check("mid_rst");
        q.delete();
        e = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, N);
        step("post2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N);
        step("post3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, I);
        #3;
        chk("drain", 16'(q.size()), 16'd1);
        if (q.size() > 0) begin
            chk("final outs", outs(), 16'(q.pop_front()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_rw_arbiter.md
# ahb_rw_arbiter

Shares the single AHB master port of the AXI-to-AHB bridge between the write path and the read path. Each cycle it picks at most one beat from the write and read request signals, drives the AHB address-phase controls, and tracks which direction occupies the AHB address and data phases. It produces the `w_phase1`/`w_phase2` and `r_phase1`/`r_phase2` signals consumed by the request logic.

## Interface
- `MAX_HOLD`, 16: maximum consecutive beats granted to one direction while the other direction is requesting. Range 1..255.

- `clk`  in  1  bridge clock
- `rst_n`  in  1  asynchronous active-low reset
- `w_req`  in  1  write beat ready (AW/W available, B space free)
- `w_last`  in  1  pending write beat is the last beat of its AXI burst
- `r_req`  in  1  read beat ready (AR available, R space free)
- `r_last`  in  1  pending read beat is the last beat of its AXI burst
- `hready`  in  1  AHB transfer-complete / pipeline-advance
- `grant_w`  out  1  write beat accepted this cycle (pop strobe)
- `grant_r`  out  1  read beat accepted this cycle (pop strobe)
- `htrans`  out  2  AHB HTRANS for the current address phase
- `hwrite`  out  1  AHB HWRITE for the current address phase
- `w_phase1`  out  1  write transfer in address phase
- `r_phase1`  out  1  read transfer in address phase
- `w_phase2`  out  1  write transfer in data phase
- `r_phase2`  out  1  read transfer in data phase

## Operation
- **Arbitration point:** a cycle with `hready`=1.
  - With `hready`=0: `grant_*`=0 and every registered output holds.
- **Pick:**
  - If only one request is high, that direction wins.
  - If both are high, the direction not granted last wins (round-robin bit `last_dir`; reset value is read, so write wins the first contention).
- **Lock:** when the lock feature is enabled and a burst is in progress, the locked direction is the only candidate (see Configuration).
- **Grant:** `grant_x` = `hready` & picked & `x_req`. Both grants are never high in the same cycle.
- **Pipeline on `hready`=1:**
  - `{w,r}_phase2` takes the value of `{w,r}_phase1`.
  - `{w,r}_phase1` takes `{grant_w,grant_r}`.
  - `hwrite` takes `grant_w`.
  - `htrans` takes IDLE if there is no grant, SEQ if the grant continues a locked burst, and NONSEQ otherwise.
- **Hold counter `hold_cnt`:**
  - Increments on a grant to the same direction as `last_dir`.
  - Loads 1 on a direction change.
  - Saturates at `MAX_HOLD`.
  - When `hold_cnt`==`MAX_HOLD` and the other direction requests, the current direction is ineligible at the next arbitration point, even mid-lock. The lock is dropped and the next beat of the broken burst is NONSEQ.
- **Encodings:** `htrans` values are IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11. BUSY is never driven.
- **Reset:** while `rst_n` is low, every output and state bit is 0 (`htrans` IDLE, `last_dir` = read, unlocked, `hold_cnt`=0). Reset mid-burst abandons the burst with no completion; upstream FIFOs are reset together with this block.
- **Out of scope:** AHB ERROR responses are not handled here.

## Timing
- `grant_*` is combinational from `w_req`, `r_req`, `hready` and state, in the same cycle.
- Request accepted in cycle N (with `hready`=1):
  - `htrans`/`hwrite`/`x_phase1` are valid from N+1.
  - `x_phase2` is valid from the first `hready`=1 edge after that, i.e. N+2 with no wait states.
- Wait states (`hready`=0) freeze the address phase. AHB address stability holds because all bus outputs are registered.
- Back-to-back grants are allowed every `hready`=1 cycle. Sustained throughput is 1 beat/cycle.

## Configuration
- **`AXI_AHB_ARB_BURST_LOCK_EN` defined:**
  - A grant with `x_last`=0 sets the lock to direction x. A grant with `x_last`=1 clears it.
  - While locked, the other direction is not granted (except by the `MAX_HOLD` break).
  - Continuing beats are SEQ. A locked cycle with `hready`=1 and no request from the locked direction issues IDLE and keeps the lock; the next beat is then NONSEQ.
- **Undefined:**
  - No lock state exists and every arbitration point is a fresh round-robin pick.
  - Every beat is NONSEQ; `x_last` is ignored.
  - `MAX_HOLD` still bounds starvation.

## Structure
- **Package `axi_ahb_pkg`:**
  - `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ)
  - `dir_t` enum (DIR_R, DIR_W)
  - HTRANS localparams
- **Modules:** a single module with no sub-module. The round-robin pick is a small function in `axi_ahb_pkg`.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-burst → all outputs 0 and `htrans`=IDLE immediately; after release, the first contention grants write.
- **Contention, no lock:** `w_req`=`r_req`=1, `hready`=1 for 6 cycles (lock off) → grants alternate W,R,W,R,W,R; `htrans`=NONSEQ each cycle; phase1/phase2 follow one and two cycles later.
- **Locked burst:** with lock on, a write burst of 4 beats (`w_last` on beat 4) while `r_req`=1 → W×4 with `htrans` NONSEQ,SEQ,SEQ,SEQ, then R.
- **Starvation break:** `MAX_HOLD`=2, lock on, 5-beat write burst with `r_req`=1 → W,W,R,…; the resumed write beat is NONSEQ.
- **Wait states:** `hready`=0 for 3 cycles after a grant → no `grant_*`, and `htrans`/`hwrite`/phases stay stable across all 3 cycles.
- **Idle inside lock:** lock on, `w_req` drops mid-burst for 1 cycle → `htrans`=IDLE, no read grant, and the next write beat is NONSEQ.
